// File: rtl/bias_loader_pkg.sv
// Shared definitions for the bias loader: default sizes, FSM states,
// the bias word type and the sign-magnitude negative-zero pattern.
package bias_loader_pkg;

  localparam int NUM_CH_DEF = 16;
  localparam int BW_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef logic [BW_DEF-1:0] bias_word_t;

  localparam bias_word_t NEG_ZERO = {1'b1, {(BW_DEF-1){1'b0}}};

endpackage

// File: rtl/bias_loader.sv
// Loads NUM_CH sign-magnitude bias words into a parallel-readable flop bank,
// folding negative zero to plain zero and flagging when the bank is complete.
module bias_loader
  import bias_loader_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int BW     = BW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [BW-1:0] in_data,
  output logic          in_ready,
  output logic [BW-1:0] bias_mem [0:NUM_CH-1],
  output logic          loaded,
  output logic          done,
  output logic          busy
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);
  localparam logic [BW-1:0] NEG_ZERO_W = {1'b1, {(BW-1){1'b0}}};

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          loaded_q, loaded_d;
  logic [BW-1:0] mem_q [0:NUM_CH-1];
  logic [BW-1:0] mem_d [0:NUM_CH-1];
  logic [BW-1:0] store_word;

  assign store_word = (in_data == NEG_ZERO_W) ? '0 : in_data;

  // A start in LOAD wins over a same-cycle accept; start in DONE is ignored.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    loaded_d = loaded_q;
    mem_d    = mem_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          idx_d    = '0;
          loaded_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (start) begin
          idx_d    = '0;
          loaded_d = 1'b0;
        end else if (in_valid) begin
          mem_d[idx_q] = store_word;
          if (idx_q == LAST_IDX) begin
            state_d  = ST_DONE;
            idx_d    = '0;
            loaded_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      loaded_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      loaded_q <= loaded_d;
      mem_q    <= mem_d;
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q == ST_LOAD);
  assign done     = (state_q == ST_DONE);
  assign loaded   = loaded_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_out
    assign bias_mem[gi] = mem_q[gi];
  end

endmodule
